// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the registered ALU.
//   - opcode encodings OP_ADD..OP_MUL
//   - FSM state encodings ST_IDLE / ST_MUL / ST_HOLD
//   - flag vector bit ordering (FLAG_C/Z/N/V) and a packing helper
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Flag vector layout: {carry, zero, negative, overflow}
  localparam int FLAG_W = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic z,
                                                   input logic n, input logic v);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational result/flag generator for the single-cycle ops.
// Ports:
//   op        in  3      operation select
//   a, b      in  WIDTH  operands
//   carry_in  in  1      carry input (ADD only)
//   result    out WIDTH  operation result
//   flags     out 4      {carry, zero, negative, overflow}
// OP_MUL is not handled here: it yields result 0 (zero=1, other flags 0),
// which is exactly the behaviour wanted when the multiplier is compiled out.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              carry_in,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           c;
  logic           v;

  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        // operands agree in sign, result disagrees
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = ~diff[WIDTH];  // carry = no borrow
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR:  result = a ^ b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << b[SHW-1:0];
      default: result = '0;
    endcase
    flags = pack_flags(c, (result == '0), result[WIDTH-1], v);
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake on both sides.
// Optional macro ALU_SEQ_MUL_EN adds a WIDTH-iteration shift-add multiplier
// for op 111; without it op 111 completes in one cycle with result 0.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   request handshake; op, a, b, carry_in sampled on accept
//   out_valid/out_ready response handshake
//   result              WIDTH-bit result
//   carry_out, zero, negative, overflow   status flags
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("alu_seq: WIDTH must be in 4..32");
  end
  if (CNT_W != $clog2(WIDTH) + 1) begin : g_bad_cnt
    $error("alu_seq: CNT_W is derived from WIDTH and must not be overridden");
  end

  state_t            state, state_n;
  logic [WIDTH-1:0]  res_q;
  logic [FLAG_W-1:0] flg_q;
  logic [WIDTH-1:0]  core_res;
  logic [FLAG_W-1:0] core_flg;
  logic              accept;
  logic              is_mul;

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .op       (op),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .result   (core_res),
    .flags    (core_flg)
  );

  // HOLD accepts only when its own result leaves this same edge
  assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  assign is_mul = (op == OP_MUL);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               mul_done;

  // WIDTH iterations, then one cycle to register result and flags
  assign mul_done = (cnt == CNT_W'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if ((state == ST_MUL) && !mul_done) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign is_mul = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept)                           state_n = is_mul ? ST_MUL : ST_HOLD;
        else if ((state == ST_HOLD) && out_ready) state_n = ST_IDLE;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: if (mul_done) state_n = ST_HOLD;
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (accept && !is_mul) begin
      res_q <= core_res;
      flg_q <= core_flg;
    end
`ifdef ALU_SEQ_MUL_EN
    else if ((state == ST_MUL) && mul_done) begin
      res_q <= acc[WIDTH-1:0];
      flg_q <= pack_flags(1'b0, (acc[WIDTH-1:0] == '0), acc[WIDTH-1],
                          |acc[2*WIDTH-1:WIDTH]);
    end
`endif
  end

  assign result    = res_q;
  assign carry_out = flg_q[FLAG_C];
  assign zero      = flg_q[FLAG_Z];
  assign negative  = flg_q[FLAG_N];
  assign overflow  = flg_q[FLAG_V];

endmodule
